// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the memory-access unit (master)
// and the data memory (slave).
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Pipeline MEM stage: passes ALU results through to MEM/WB, runs load/store
// handshakes with the data memory, stalls upstream and aborts on timeout.
module mem_access_unit (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4:0]                EX_MEM_rd,
    input  logic [63:0]               EX_MEM_mux_ALU,
    input  logic [63:0]               EX_MEM_mux_ForwardB,
    input  logic                      EX_MEM_ALUzero,
    input  logic                      EX_MEM_Branch,
    input  logic                      EX_MEM_MemRead,
    input  logic                      EX_MEM_MemWrite,
    input  logic                      EX_MEM_RegWrite,
    input  logic                      EX_MEM_MemtoReg,
    mem_access_unit_if.master         memBus,
    output logic                      stall,
    output logic                      pc_src,
    output logic                      mem_err,
    output logic [4:0]                MEM_WB_rd,
    output logic [63:0]               MEM_WB_readdata,
    output logic [63:0]               MEM_WB_aluresult,
    output logic                      MEM_WB_RegWrite,
    output logic                      MEM_WB_MemtoReg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic [63:0] capAddr_q, capAddr_d;
    logic [63:0] capWdata_q, capWdata_d;
    logic [4:0]  capRd_q, capRd_d;
    logic        capRegWrite_q, capRegWrite_d;
    logic        capMemtoReg_q, capMemtoReg_d;
    logic        capWrite_q, capWrite_d;
    logic [4:0]  wbRd_q, wbRd_d;
    logic [63:0] wbReaddata_q, wbReaddata_d;
    logic [63:0] wbAlu_q, wbAlu_d;
    logic        wbRegWrite_q, wbRegWrite_d;
    logic        wbMemtoReg_q, wbMemtoReg_d;

    logic        memOp;
    logic        reqC, weC, stallC, errC;
    logic [63:0] addrC, wdataC;

    assign memOp = EX_MEM_MemRead | EX_MEM_MemWrite;

    always_comb begin
        state_d       = state_q;
        waitCnt_d     = waitCnt_q;
        capAddr_d     = capAddr_q;
        capWdata_d    = capWdata_q;
        capRd_d       = capRd_q;
        capRegWrite_d = capRegWrite_q;
        capMemtoReg_d = capMemtoReg_q;
        capWrite_d    = capWrite_q;
        wbRd_d        = wbRd_q;
        wbReaddata_d  = wbReaddata_q;
        wbAlu_d       = wbAlu_q;
        wbRegWrite_d  = wbRegWrite_q;
        wbMemtoReg_d  = wbMemtoReg_q;
        reqC          = 1'b0;
        weC           = 1'b0;
        addrC         = 64'd0;
        wdataC        = 64'd0;
        stallC        = 1'b0;
        errC          = 1'b0;

        case (state_q)
            IDLE: begin
                if (memOp) begin
                    // A simultaneous read+write is treated as a write.
                    stallC        = 1'b1;
                    capAddr_d     = EX_MEM_mux_ALU;
                    capWdata_d    = EX_MEM_mux_ForwardB;
                    capRd_d       = EX_MEM_rd;
                    capRegWrite_d = EX_MEM_RegWrite;
                    capMemtoReg_d = EX_MEM_MemtoReg;
                    capWrite_d    = EX_MEM_MemWrite;
                    waitCnt_d     = 8'd0;
                    wbRegWrite_d  = 1'b0;
                    state_d       = BUSY;
                end else begin
                    wbRd_d       = EX_MEM_rd;
                    wbAlu_d      = EX_MEM_mux_ALU;
                    wbRegWrite_d = EX_MEM_RegWrite;
                    wbMemtoReg_d = EX_MEM_MemtoReg;
                end
            end
            BUSY: begin
                reqC   = 1'b1;
                weC    = capWrite_q;
                addrC  = capAddr_q;
                wdataC = capWdata_q;
                if (memBus.mem_ack) begin
                    if (!capWrite_q) begin
                        wbReaddata_d = memBus.mem_rdata;
                    end
                    wbRd_d       = capRd_q;
                    wbAlu_d      = capAddr_q;
                    wbRegWrite_d = capRegWrite_q;
                    wbMemtoReg_d = capMemtoReg_q;
                    state_d      = IDLE;
                end else begin
                    stallC       = 1'b1;
                    wbRegWrite_d = 1'b0;
                    if (waitCnt_q == 8'd255) begin
                        state_d = ABORT;
                    end else begin
                        waitCnt_d = waitCnt_q + 8'd1;
                    end
                end
            end
            ABORT: begin
                errC         = 1'b1;
                stallC       = 1'b1;
                wbRegWrite_d = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            waitCnt_q     <= 8'd0;
            capAddr_q     <= 64'd0;
            capWdata_q    <= 64'd0;
            capRd_q       <= 5'd0;
            capRegWrite_q <= 1'b0;
            capMemtoReg_q <= 1'b0;
            capWrite_q    <= 1'b0;
            wbRd_q        <= 5'd0;
            wbReaddata_q  <= 64'd0;
            wbAlu_q       <= 64'd0;
            wbRegWrite_q  <= 1'b0;
            wbMemtoReg_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            waitCnt_q     <= waitCnt_d;
            capAddr_q     <= capAddr_d;
            capWdata_q    <= capWdata_d;
            capRd_q       <= capRd_d;
            capRegWrite_q <= capRegWrite_d;
            capMemtoReg_q <= capMemtoReg_d;
            capWrite_q    <= capWrite_d;
            wbRd_q        <= wbRd_d;
            wbReaddata_q  <= wbReaddata_d;
            wbAlu_q       <= wbAlu_d;
            wbRegWrite_q  <= wbRegWrite_d;
            wbMemtoReg_q  <= wbMemtoReg_d;
        end
    end

    // While reset is held low the bus and control outputs are forced quiet,
    // even before the first reset edge has cleared the state register.
    assign memBus.mem_req   = reset & reqC;
    assign memBus.mem_we    = reset & weC;
    assign memBus.mem_addr  = reset ? addrC : 64'd0;
    assign memBus.mem_wdata = reset ? wdataC : 64'd0;
    assign stall            = reset & stallC;
    assign mem_err          = reset & errC;
    assign pc_src           = EX_MEM_Branch & EX_MEM_ALUzero;

    assign MEM_WB_rd        = wbRd_q;
    assign MEM_WB_readdata  = wbReaddata_q;
    assign MEM_WB_aluresult = wbAlu_q;
    assign MEM_WB_RegWrite  = wbRegWrite_q;
    assign MEM_WB_MemtoReg  = wbMemtoReg_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed and random operations
// checked against a transaction-level model of the MEM stage.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  EX_MEM_rd;
    logic [63:0] EX_MEM_mux_ALU;
    logic [63:0] EX_MEM_mux_ForwardB;
    logic        EX_MEM_ALUzero;
    logic        EX_MEM_Branch;
    logic        EX_MEM_MemRead;
    logic        EX_MEM_MemWrite;
    logic        EX_MEM_RegWrite;
    logic        EX_MEM_MemtoReg;
    logic        stall;
    logic        pc_src;
    logic        mem_err;
    logic [4:0]  MEM_WB_rd;
    logic [63:0] MEM_WB_readdata;
    logic [63:0] MEM_WB_aluresult;
    logic        MEM_WB_RegWrite;
    logic        MEM_WB_MemtoReg;

    int checks = 0;
    int failures = 0;

    // Expected MEM/WB contents as seen by the write-back stage.
    logic [4:0]  mRd;
    logic [63:0] mReaddata;
    logic [63:0] mAlu;
    logic        mRegWrite;
    logic        mMemtoReg;

    mem_access_unit_if bus();

    mem_access_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .EX_MEM_rd           (EX_MEM_rd),
        .EX_MEM_mux_ALU      (EX_MEM_mux_ALU),
        .EX_MEM_mux_ForwardB (EX_MEM_mux_ForwardB),
        .EX_MEM_ALUzero      (EX_MEM_ALUzero),
        .EX_MEM_Branch       (EX_MEM_Branch),
        .EX_MEM_MemRead      (EX_MEM_MemRead),
        .EX_MEM_MemWrite     (EX_MEM_MemWrite),
        .EX_MEM_RegWrite     (EX_MEM_RegWrite),
        .EX_MEM_MemtoReg     (EX_MEM_MemtoReg),
        .memBus              (bus.master),
        .stall               (stall),
        .pc_src              (pc_src),
        .mem_err             (mem_err),
        .MEM_WB_rd           (MEM_WB_rd),
        .MEM_WB_readdata     (MEM_WB_readdata),
        .MEM_WB_aluresult    (MEM_WB_aluresult),
        .MEM_WB_RegWrite     (MEM_WB_RegWrite),
        .MEM_WB_MemtoReg     (MEM_WB_MemtoReg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkWb(input string tag);
        checkOutput({tag, "_rd"}, 64'(MEM_WB_rd), 64'(mRd));
        checkOutput({tag, "_readdata"}, MEM_WB_readdata, mReaddata);
        checkOutput({tag, "_alu"}, MEM_WB_aluresult, mAlu);
        checkOutput({tag, "_regwrite"}, 64'(MEM_WB_RegWrite), 64'(mRegWrite));
        checkOutput({tag, "_memtoreg"}, 64'(MEM_WB_MemtoReg), 64'(mMemtoReg));
    endtask

    task automatic applyStimulus(input logic rdOp, input logic wrOp, input logic [4:0] rd,
                                 input logic [63:0] alu, input logic [63:0] fwdB,
                                 input logic regWrite, input logic memtoReg);
        EX_MEM_MemRead      = rdOp;
        EX_MEM_MemWrite     = wrOp;
        EX_MEM_rd           = rd;
        EX_MEM_mux_ALU      = alu;
        EX_MEM_mux_ForwardB = fwdB;
        EX_MEM_RegWrite     = regWrite;
        EX_MEM_MemtoReg     = memtoReg;
        EX_MEM_Branch       = 1'($urandom_range(0, 1));
        EX_MEM_ALUzero      = 1'($urandom_range(0, 1));
    endtask

    // One instruction through the MEM stage; the memory acks after
    // waitCycles request cycles, or never if waitCycles > 255.
    task automatic runOp(input logic rdOp, input logic wrOp, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] fwdB,
                         input logic regWrite, input logic memtoReg,
                         input int waitCycles, input logic [63:0] rdata);
        logic memOp;
        logic isWrite;
        memOp   = rdOp | wrOp;
        isWrite = wrOp;
        @(negedge clk);
        applyStimulus(rdOp, wrOp, rd, alu, fwdB, regWrite, memtoReg);
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = {$urandom, $urandom};
        #1;
        checkOutput("issue_stall", 64'(stall), 64'(memOp));
        checkOutput("issue_req", 64'(bus.mem_req), 64'd0);
        checkOutput("issue_pcsrc", 64'(pc_src), 64'(EX_MEM_Branch & EX_MEM_ALUzero));
        @(posedge clk);
        #1;
        if (!memOp) begin
            mRd = rd; mAlu = alu; mRegWrite = regWrite; mMemtoReg = memtoReg;
            checkWb("pass");
            return;
        end
        for (int k = 0; k <= 255; k++) begin
            @(negedge clk);
            bus.mem_ack         = (k == waitCycles);
            bus.mem_rdata       = (k == waitCycles) ? rdata : {$urandom, $urandom};
            EX_MEM_mux_ALU      = {$urandom, $urandom};
            EX_MEM_mux_ForwardB = {$urandom, $urandom};
            EX_MEM_rd           = 5'($urandom);
            EX_MEM_Branch       = 1'b1;
            EX_MEM_ALUzero      = 1'($urandom_range(0, 1));
            #1;
            checkOutput("busy_req", 64'(bus.mem_req), 64'd1);
            checkOutput("busy_addr", bus.mem_addr, alu);
            checkOutput("busy_wdata", bus.mem_wdata, fwdB);
            checkOutput("busy_we", 64'(bus.mem_we), 64'(isWrite));
            checkOutput("busy_stall", 64'(stall), 64'(k != waitCycles));
            checkOutput("busy_err", 64'(mem_err), 64'd0);
            checkOutput("busy_pcsrc", 64'(pc_src), 64'(EX_MEM_ALUzero));
            @(posedge clk);
            #1;
            if (k == waitCycles) begin
                mRd = rd; mAlu = alu; mRegWrite = regWrite; mMemtoReg = memtoReg;
                if (!isWrite) mReaddata = rdata;
                checkWb("done");
                return;
            end
            checkOutput("bubble_regwrite", 64'(MEM_WB_RegWrite), 64'd0);
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        bus.mem_ack = 1'b1;
        #1;
        checkOutput("abort_err", 64'(mem_err), 64'd1);
        checkOutput("abort_stall", 64'(stall), 64'd1);
        checkOutput("abort_req", 64'(bus.mem_req), 64'd0);
        @(posedge clk);
        #1;
        mRegWrite = 1'b0;
        checkOutput("abort_regwrite", 64'(MEM_WB_RegWrite), 64'd0);
        checkOutput("post_abort_err", 64'(mem_err), 64'd0);
        checkOutput("post_abort_stall", 64'(stall), 64'd0);
    endtask

    initial begin
        $display("[TB] start");
        // Reset with a memory operation and an ack pending on the inputs.
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 5'd3, 64'h100, 64'h200, 1'b1, 1'b1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h1234;
        @(negedge clk);
        #1;
        checkOutput("rst_stall", 64'(stall), 64'd0);
        checkOutput("rst_req", 64'(bus.mem_req), 64'd0);
        checkOutput("rst_we", 64'(bus.mem_we), 64'd0);
        checkOutput("rst_addr", bus.mem_addr, 64'd0);
        checkOutput("rst_wdata", bus.mem_wdata, 64'd0);
        checkOutput("rst_err", 64'(mem_err), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        mRd = 5'd0; mReaddata = 64'd0; mAlu = 64'd0; mRegWrite = 1'b0; mMemtoReg = 1'b0;
        checkWb("rst");
        reset = 1'b1;

        // Directed: pass-through, load with wait, store with immediate ack.
        runOp(1'b0, 1'b0, 5'd5, 64'h10, 64'h0, 1'b1, 1'b0, 0, 64'h0);
        runOp(1'b1, 1'b0, 5'd7, 64'h40, 64'h99, 1'b1, 1'b1, 3, 64'hDEAD);
        runOp(1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0, 0, 64'h0);
        runOp(1'b0, 1'b1, 5'd9, 64'h48, 64'h55, 1'b0, 1'b0, 0, 64'hBEEF);
        runOp(1'b1, 1'b1, 5'd11, 64'h50, 64'h77, 1'b0, 1'b0, 1, 64'hCAFE);

        // Timeout, then an ack on the last allowed wait cycle.
        runOp(1'b1, 1'b0, 5'd12, 64'h60, 64'h0, 1'b1, 1'b1, 1000, 64'h0);
        runOp(1'b1, 1'b0, 5'd13, 64'h68, 64'h0, 1'b1, 1'b1, 255, 64'hF00D);

        // Reset in the second BUSY cycle, coinciding with an ack.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 5'd14, 64'h80, 64'h0, 1'b1, 1'b0);
        bus.mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("busy1_req", 64'(bus.mem_req), 64'd1);
        @(negedge clk);
        reset         = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h5151;
        #1;
        checkOutput("midrst_req", 64'(bus.mem_req), 64'd0);
        checkOutput("midrst_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        mRd = 5'd0; mReaddata = 64'd0; mAlu = 64'd0; mRegWrite = 1'b0; mMemtoReg = 1'b0;
        checkWb("midrst");
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        runOp(1'b0, 1'b0, 5'd15, 64'hAA, 64'h0, 1'b1, 1'b1, 0, 64'h0);

        // Random mix of pass-through, loads and stores, back to back.
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            runOp(1'(kind[0]), 1'(kind[1]), 5'($urandom), {$urandom, $urandom},
                  {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 4), {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
